// File: rtl/cdc_fifo_src_arbiter.sv
// Round-robin burst-locking arbiter feeding the source side of a clearable CDC FIFO.
// Optional per-channel accepted-beat counters: define CDC_FIFO_SRC_ARBITER_STATS_EN.
module cdc_fifo_src_arbiter #(
    parameter int unsigned NumInp   = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MaxBurst = 4,
    localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    output logic                     clear_busy_o,
    input  logic [NumInp*WIDTH-1:0]  inp_data_i,
    input  logic [NumInp-1:0]        inp_valid_i,
    output logic [NumInp-1:0]        inp_ready_o,
    output logic [WIDTH-1:0]         oup_data_o,
    output logic [IdxWidth-1:0]      oup_idx_o,
    output logic                     oup_valid_o,
    input  logic                     oup_ready_i,
    output logic                     fifo_clear_o,
    input  logic                     fifo_clear_pending_i
`ifdef CDC_FIFO_SRC_ARBITER_STATS_EN
    ,
    output logic [NumInp*16-1:0]     stats_o
`endif
);

    localparam int unsigned BeatWidth = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

    typedef enum logic [1:0] {ARB, CLR_REQ, CLR_WAIT_HI, CLR_WAIT_LO} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   rr_q, idx_q, last_idx_q;
    logic [IdxWidth-1:0]   scan_idx, sel, sel_inc;
    logic [BeatWidth-1:0]  beat_q;
    logic                  lock_q;
    logic                  in_arb, handshake, release_lock, burst_done;
    int unsigned           sel_base;

    // First valid requester scanning upward from rr_q; loop runs backwards so the nearest wins.
    always_comb begin
        int unsigned j;
        scan_idx = rr_q;
        for (int unsigned k = 0; k < NumInp; k++) begin
            j = (32'(rr_q) + (NumInp - 1 - k)) % NumInp;
            if (inp_valid_i[j]) scan_idx = IdxWidth'(j);
        end
    end

    assign sel          = lock_q ? idx_q : scan_idx;
    assign sel_inc      = (32'(sel) == NumInp - 1) ? '0 : sel + IdxWidth'(1);
    assign sel_base     = 32'(sel) * WIDTH;
    assign in_arb       = (state_q == ARB);
    assign oup_valid_o  = in_arb && !clear_i && inp_valid_i[sel];
    assign handshake    = oup_valid_o && oup_ready_i;
    assign release_lock = lock_q && !inp_valid_i[idx_q];
    assign burst_done   = (32'(beat_q) + 32'd1) >= MaxBurst;
    assign oup_data_o   = oup_valid_o ? inp_data_i[sel_base +: WIDTH] : '0;
    assign oup_idx_o    = oup_valid_o ? sel : last_idx_q;
    assign fifo_clear_o = (state_q == CLR_REQ);
    assign clear_busy_o = !in_arb;

    always_comb begin
        inp_ready_o = '0;
        if (in_arb && !clear_i) inp_ready_o[sel] = oup_ready_i;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (clear_i)                   state_d = CLR_REQ;
                else if (fifo_clear_pending_i) state_d = CLR_WAIT_LO;
            end
            CLR_REQ:     state_d = CLR_WAIT_HI;
            CLR_WAIT_HI: if (fifo_clear_pending_i)  state_d = CLR_WAIT_LO;
            CLR_WAIT_LO: if (!fifo_clear_pending_i) state_d = ARB;
            default:     state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            idx_q      <= '0;
            beat_q     <= '0;
            last_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (oup_valid_o) last_idx_q <= sel;
            // Arbitration state is held at zero for the whole clear sequence, which equals zeroing on entry.
            if (!in_arb || state_d != ARB) begin
                rr_q   <= '0;
                lock_q <= 1'b0;
                idx_q  <= '0;
                beat_q <= '0;
            end else if (release_lock) begin
                lock_q <= 1'b0;
                beat_q <= '0;
                rr_q   <= sel_inc;
            end else if (handshake) begin
                if (!burst_done) begin
                    beat_q <= beat_q + BeatWidth'(1);
                    lock_q <= 1'b1;
                    idx_q  <= sel;
                end else begin
                    beat_q <= '0;
                    lock_q <= 1'b0;
                    rr_q   <= sel_inc;
                end
            end else if (oup_valid_o) begin
                lock_q <= 1'b1;
                idx_q  <= sel;
            end
        end
    end

`ifdef CDC_FIFO_SRC_ARBITER_STATS_EN
    logic [NumInp-1:0][15:0] cnt_q;

    assign stats_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_d != state_q && (state_d == CLR_REQ || state_d == CLR_WAIT_LO)) begin
            cnt_q <= '0;
        end else if (handshake && cnt_q[sel] != 16'hFFFF) begin
            cnt_q[sel] <= cnt_q[sel] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Self-checking bench for cdc_fifo_src_arbiter: vector table, directed corner cases,
// and randomized traffic compared against a transaction-level reference model.
module tb_cdc_fifo_src_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic           busy;
    logic [N*W-1:0] inp_data;
    logic [N-1:0]   inp_valid;
    logic [N-1:0]   inp_ready;
    logic [W-1:0]   oup_data;
    logic [1:0]     oup_idx;
    logic           oup_valid;
    logic           oup_ready;
    logic           fifo_clear;
    logic           pending;
`ifdef CDC_FIFO_SRC_ARBITER_STATS_EN
    logic [N*16-1:0] stats;
`endif

    always #5 clk = ~clk;

    cdc_fifo_src_arbiter #(.NumInp(N), .WIDTH(W), .MaxBurst(MB)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .clear_i              (clear),
        .clear_busy_o         (busy),
        .inp_data_i           (inp_data),
        .inp_valid_i          (inp_valid),
        .inp_ready_o          (inp_ready),
        .oup_data_o           (oup_data),
        .oup_idx_o            (oup_idx),
        .oup_valid_o          (oup_valid),
        .oup_ready_i          (oup_ready),
        .fifo_clear_o         (fifo_clear),
        .fifo_clear_pending_i (pending)
`ifdef CDC_FIFO_SRC_ARBITER_STATS_EN
        ,
        .stats_o              (stats)
`endif
    );

    int passed = 0;
    int total  = 0;
    bit rand_data = 1'b0;

    // Reference model: phase 0 arbitrate, 1 clear pulse, 2 await pending high, 3 await pending low.
    int m_phase, m_owner, m_beats, m_next, m_last;

    typedef struct {
        logic [N-1:0] v;
        logic         r, c, p;
        logic         ev;
        logic [1:0]   eidx;
        logic         efc, ebusy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [N-1:0] v, logic r, logic c, logic p,
                                logic ev, logic [1:0] eidx, logic efc, logic ebusy);
        vec_t t;
        t.v = v; t.r = r; t.c = c; t.p = p;
        t.ev = ev; t.eidx = eidx; t.efc = efc; t.ebusy = ebusy;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = -1; m_beats = 0; m_next = 0; m_last = 0;
    endtask

    task automatic model_clr();
        m_owner = -1; m_beats = 0; m_next = 0;
    endtask

    task automatic model_step();
        int g;
        bit found;
        logic [N-1:0] er;
        g = -1;
        found = 1'b0;
        if (m_phase == 0 && !clear) begin
            if (m_owner >= 0) begin
                if (inp_valid[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_next + k) % N;
                    if (!found && inp_valid[c]) begin
                        g = c;
                        found = 1'b1;
                    end
                end
            end
        end
        check("m_valid", 32'(oup_valid), 32'(g >= 0));
        check("m_idx", 32'(oup_idx), (g >= 0) ? 32'(g) : 32'(m_last));
        if (g >= 0) check("m_data", oup_data, inp_data[g*W +: W]);
        er = '0;
        if (g >= 0 && oup_ready) er[g] = 1'b1;
        if (g >= 0 || m_phase != 0 || clear) check("m_ready", 32'(inp_ready), 32'(er));
        check("m_fifo_clear", 32'(fifo_clear), 32'(m_phase == 1));
        check("m_busy", 32'(busy), 32'(m_phase != 0));

        if (g >= 0) m_last = g;
        case (m_phase)
            0: begin
                if (clear) begin
                    m_phase = 1; model_clr();
                end else if (pending) begin
                    m_phase = 3; model_clr();
                end else if (m_owner >= 0 && !inp_valid[m_owner]) begin
                    m_next = (m_owner + 1) % N; m_owner = -1; m_beats = 0;
                end else if (g >= 0) begin
                    if (oup_ready) begin
                        m_beats++;
                        if (m_beats < MB) m_owner = g;
                        else begin
                            m_beats = 0; m_owner = -1; m_next = (g + 1) % N;
                        end
                    end else begin
                        m_owner = g;
                    end
                end
            end
            1: m_phase = 2;
            2: if (pending) m_phase = 3;
            default: if (!pending) m_phase = 0;
        endcase
    endtask

    // Drive one cycle's inputs just after posedge, then evaluate at the following negedge.
    task automatic apply(logic [N-1:0] v, logic r, logic c, logic p);
        inp_valid = v; oup_ready = r; clear = c; pending = p;
        for (int i = 0; i < N; i++)
            inp_data[i*W +: W] = rand_data ? $urandom : (32'hD000_0000 | 32'(i));
        @(negedge clk);
        model_step();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inp_valid = '0; oup_ready = 1'b0; clear = 1'b0; pending = 1'b0; inp_data = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_valid", 32'(oup_valid), 32'd0);
        check("rst_ready", 32'(inp_ready), 32'd0);
        check("rst_fifo_clear", 32'(fifo_clear), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(oup_idx), 32'd0);
        check("rst_data", oup_data, 32'd0);
        model_reset();
        rst_n = 1'b1;
        tick();
    endtask

    int wait_cnt, hold_cnt;
    logic p;

    initial begin
        // Bursts of four per channel, then a local clear with a 3-cycle pending pulse.
        for (int i = 0; i < 17; i++) tbl.push_back(mk(4'hF, 1, 0, 0, 1, 2'((i / 4) % 4), 0, 0));
        tbl.push_back(mk(4'hF, 1, 1, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(4'hF, 1, 0, 0, 0, 2'd0, 1, 1));
        tbl.push_back(mk(4'hF, 1, 0, 0, 0, 2'd0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'hF, 1, 0, 1, 0, 2'd0, 0, 1));
        tbl.push_back(mk(4'hF, 1, 0, 0, 0, 2'd0, 0, 1));
        tbl.push_back(mk(4'hF, 1, 0, 0, 1, 2'd0, 0, 0));
        tbl.push_back(mk(4'hF, 1, 0, 0, 1, 2'd0, 0, 0));

        do_reset();
        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].p);
            check("tbl_valid", 32'(oup_valid), 32'(tbl[i].ev));
            check("tbl_idx", 32'(oup_idx), 32'(tbl[i].eidx));
            check("tbl_fifo_clear", 32'(fifo_clear), 32'(tbl[i].efc));
            check("tbl_busy", 32'(busy), 32'(tbl[i].ebusy));
            tick();
        end

        // Stall on ch1 while ch3 also requests: grant and payload must not move.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(4'b1010, 0, 0, 0);
            check("stall_idx", 32'(oup_idx), 32'd1);
            check("stall_data", oup_data, 32'hD000_0001);
            check("stall_ready", 32'(inp_ready), 32'd0);
            tick();
        end
        apply(4'b1010, 1, 0, 0);
        check("stall_accept", 32'(inp_ready), 32'b0010);
        tick();

        // ch2 gives two beats then drops: release cycle idle, then ch3 is next.
        do_reset();
        apply(4'b0100, 1, 0, 0); check("gap_idx0", 32'(oup_idx), 32'd2); tick();
        apply(4'b0100, 1, 0, 0); check("gap_idx1", 32'(oup_idx), 32'd2); tick();
        apply(4'b1001, 1, 0, 0); check("gap_release", 32'(oup_valid), 32'd0); tick();
        apply(4'b1001, 1, 0, 0); check("gap_next", 32'(oup_idx), 32'd3); tick();

        // Destination-initiated clear withdraws a stalled beat, which is re-sent afterwards.
        do_reset();
        apply(4'b0010, 0, 0, 0); check("ext_grant", 32'(oup_idx), 32'd1); tick();
        apply(4'b0010, 0, 0, 1); check("ext_no_pulse", 32'(fifo_clear), 32'd0); tick();
        for (int i = 0; i < 2; i++) begin
            apply(4'b0010, 1, 0, 1);
            check("ext_ready", 32'(inp_ready), 32'd0);
            check("ext_fc", 32'(fifo_clear), 32'd0);
            tick();
        end
        apply(4'b0010, 1, 0, 0); check("ext_busy", 32'(busy), 32'd1); tick();
        apply(4'b0010, 1, 0, 0); check("ext_resend", 32'(inp_ready), 32'b0010); tick();

        // Reset in the middle of a clear sequence.
        do_reset();
        apply(4'hF, 1, 1, 0); tick();
        apply(4'hF, 1, 0, 0); tick();
        apply(4'hF, 1, 0, 0); check("mid_busy", 32'(busy), 32'd1); tick();
        do_reset();

        // Randomized traffic; pending emulates the FIFO's clear handshake plus spontaneous remote clears.
        rand_data = 1'b1;
        wait_cnt = 0;
        hold_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 600) == 0) begin
                do_reset();
                wait_cnt = 0;
                hold_cnt = 0;
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) hold_cnt = $urandom_range(1, 4);
            end else if (hold_cnt == 0 && $urandom_range(0, 80) == 0) begin
                hold_cnt = $urandom_range(1, 3);
            end
            p = 1'b0;
            if (hold_cnt > 0) begin
                p = 1'b1;
                hold_cnt--;
            end
            apply(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 60) == 0, p);
            if (fifo_clear) wait_cnt = $urandom_range(1, 3);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cdc_fifo_src_arbiter.md
Name: cdc_fifo_src_arbiter

Overview:
- Shares the source side of a clearable gray-code CDC FIFO between NumInp streaming requesters, in the source clock domain.
- Arbitrates round-robin with bounded burst locking and forwards the winning channel index alongside the data.
- Sequences FIFO clears: issues the clear pulse, isolates all requesters, and waits for the FIFO's clear-pending handshake to finish. This covers clears started locally and clears started by the destination side.

Parameters:
- NumInp, 4, number of requesters (≥2).
- WIDTH, 32, payload width in bits.
- MaxBurst, 4, max beats granted consecutively to one requester (1 = per-beat round-robin).
- IdxWidth, $clog2(NumInp), derived localparam, channel index width.

Ports:
- clk_i  in  1  source-domain clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear request, one-cycle pulse or level.
- clear_busy_o  out  1  clear sequence in progress.
- inp_data_i  in  NumInp*WIDTH  requester payloads; channel i at bits [i*WIDTH +: WIDTH].
- inp_valid_i  in  NumInp  requester valid.
- inp_ready_o  out  NumInp  requester ready.
- oup_data_o  out  WIDTH  payload to FIFO src_data_i.
- oup_idx_o  out  IdxWidth  granted channel index.
- oup_valid_o  out  1  to FIFO src_valid_i.
- oup_ready_i  in  1  from FIFO src_ready_o.
- fifo_clear_o  out  1  to FIFO src_clear_i.
- fifo_clear_pending_i  in  1  from FIFO src_clear_pending_o.

Behaviour:
- Reset values:
  - Outputs: all 0, including oup_valid_o, inp_ready_o, fifo_clear_o and clear_busy_o.
  - Internal: state=ARB, rr_q=0, lock_q=0, idx_q=0, beat_q=0.
- Datapath is combinational from the selected input (0-cycle latency). oup_data_o and oup_idx_o follow sel.
- Only inp_ready_o[sel] may be 1; it equals oup_ready_i in ARB, otherwise 0.
- Selection:
  - If lock_q=1, sel=idx_q.
  - Otherwise sel is the first i with inp_valid_i[i]=1, scanning rr_q, rr_q+1, … mod NumInp.
  - If no input is valid, oup_valid_o=0 and oup_idx_o holds its last value.
- Stability: if oup_valid_o=1 and oup_ready_i=0, then lock_q←1 and idx_q←sel. Grant, data and index stay stable until the handshake, so the output obeys valid-hold even when other requesters assert.
- On handshake (oup_valid_o & oup_ready_i):
  - If beat_q+1 < MaxBurst: beat_q++, lock_q←1, idx_q←sel.
  - Otherwise: beat_q←0, lock_q←0, rr_q←(sel+1) mod NumInp.
- Release: if lock_q=1 and inp_valid_i[idx_q]=0 (requester gap after a completed beat), then lock_q←0, beat_q←0, rr_q←(idx_q+1) mod NumInp. No beat is transferred that cycle.
- rr_q wraps NumInp-1→0.
- FSM states: ARB, CLR_REQ, CLR_WAIT_HI, CLR_WAIT_LO.
- ARB:
  - clear_i=1 → CLR_REQ. The request takes priority over a same-cycle handshake: oup_valid_o is forced to 0 that cycle.
  - Otherwise fifo_clear_pending_i=1 (destination-initiated clear) → CLR_WAIT_LO.
- CLR_REQ: fifo_clear_o=1 for exactly one cycle → CLR_WAIT_HI.
- CLR_WAIT_HI: wait for fifo_clear_pending_i=1 → CLR_WAIT_LO.
- CLR_WAIT_LO: wait for fifo_clear_pending_i=0 → ARB.
- All non-ARB states:
  - oup_valid_o=0, inp_ready_o=0, clear_busy_o=1.
  - rr_q, lock_q, idx_q and beat_q are reset to 0 on entry.
  - clear_i is ignored; a level held after return to ARB starts a new sequence.
- An in-flight unaccepted beat is withdrawn by the clear; the requester keeps it and re-presents it afterwards. This is the only permitted valid-hold exception.
- Asynchronous reset mid-sequence returns the FSM to ARB with the reset values above.

Optional Feature:
- Macro: CDC_FIFO_SRC_ARBITER_STATS_EN.
- When defined:
  - Adds output stats_o [NumInp*16]: per-channel 16-bit saturating counters of accepted beats (saturate at 16'hFFFF).
  - Counters are zeroed by reset and on entry to CLR_REQ or CLR_WAIT_LO.
- When undefined: no port and no counter logic.

Test Plan:
- Setup: NumInp=4, MaxBurst=4, oup_ready_i=1. All four requesters continuously valid → oup_idx_o sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…
- MaxBurst=1, valid only on ch1 and ch3 → idx alternates 1,3,1,3. With oup_ready_i=0 for 5 cycles on ch1: idx and data are stable; ch3 valid does not steal the grant.
- ch2 bursts 2 beats then drops valid → lock released, rr_q=3; next grant goes to ch3 if valid, else ch0.
- clear_i pulse with oup_valid_o=1:
  - Same cycle: oup_valid_o=0.
  - Next cycle: fifo_clear_o=1 for 1 cycle.
  - Pending is driven high 3 cycles then low: clear_busy_o=1 throughout; ARB resumes the cycle after pending falls, with the rr_q=0 grant.
- fifo_clear_pending_i raised externally in ARB → fifo_clear_o stays 0; all readies 0 until pending falls; the granted requester's unaccepted beat is re-sent afterwards.
- With CDC_FIFO_SRC_ARBITER_STATS_EN: 10 beats ch0 + 3 beats ch2 → stats {0,3,0,10} (ch3..ch0); a clear then zeroes all counters.
